// File: rtl/dff_bank_arbiter_pkg.sv
// Shared types and constants for the DFF bank arbiter slice.
package dff_arb_pkg;

    // Transaction phases: wait for a request, commit the data, report completion.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } arb_state_t;

    // Width of the committed-write counter.
    localparam int CNT_W = 16;

endpackage : dff_arb_pkg

// File: rtl/dff_bank_arbiter_dff_reg.sv
// WIDTH-bit storage register with load enable and asynchronous clear.
module dff_reg
    import dff_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d when enabled; hold otherwise; clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : dff_reg

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter giving N_REQ requesters write access to one shared
// storage register. Each transaction is IDLE -> WRITE -> ACK -> IDLE.
module dff_bank_arbiter
    import dff_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data_in,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid,
    output logic [IDXW-1:0]        owner,
    output logic                   busy,
    output logic [CNT_W-1:0]       xfer_cnt
);

    arb_state_t       state_reg;
    arb_state_t       state_next;
    logic [IDXW-1:0]  gidx_reg;
    logic [IDXW-1:0]  gidx_next;
    logic [IDXW-1:0]  rr_ptr_reg;
    logic [IDXW-1:0]  owner_reg;
    logic             q_valid_reg;
    logic [CNT_W-1:0] xfer_cnt_reg;

    logic [IDXW-1:0]  winner;
    logic             winner_found;
    logic [WIDTH-1:0] sel_data;
    logic             wr_en;

    // Pick the first asserted request scanning upward from rr_ptr, wrapping
    // explicitly so a non-power-of-2 N_REQ never yields an out-of-range index.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            automatic int              idx  = int'(rr_ptr_reg) + k;
            automatic logic [IDXW-1:0] cand;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = IDXW'(idx);
            if (!winner_found && req[cand]) begin
                winner_found = 1'b1;
                winner       = cand;
            end
        end
    end

    // Next-state logic; the granted index is latched only when leaving IDLE,
    // so requests arriving mid-transaction cannot disturb it.
    always_comb begin
        state_next = state_reg;
        gidx_next  = gidx_reg;
        case (state_reg)
            IDLE: begin
                if (winner_found) begin
                    gidx_next  = winner;
                    state_next = WRITE;
                end
            end
            WRITE:   state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State and granted-index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            gidx_reg  <= '0;
        end else begin
            state_reg <= state_next;
            gidx_reg  <= gidx_next;
        end
    end

    // Commit bookkeeping on the WRITE->ACK edge; happens regardless of whether
    // the requester still holds req, since the grant was already issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg    <= '0;
            q_valid_reg  <= 1'b0;
            xfer_cnt_reg <= '0;
        end else if (state_reg == WRITE) begin
            owner_reg    <= gidx_reg;
            q_valid_reg  <= 1'b1;
            xfer_cnt_reg <= xfer_cnt_reg + CNT_W'(1);
        end
    end

    // Advance the round-robin pointer past the requester just served, so a
    // requester that keeps req high drops to lowest priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= '0;
        end else if (state_reg == ACK) begin
            if (gidx_reg == IDXW'(N_REQ - 1)) begin
                rr_ptr_reg <= '0;
            end else begin
                rr_ptr_reg <= gidx_reg + IDXW'(1);
            end
        end
    end

    // Select the granted requester's data slice for the storage register.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gidx_reg == IDXW'(i)) begin
                sel_data = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign wr_en = (state_reg == WRITE);

    dff_reg #(
        .WIDTH (WIDTH)
    ) u_store (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wr_en),
        .d     (sel_data),
        .q     (q)
    );

    // One-hot Moore decodes of grant and ack from the state and latched index.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_decode
            assign grant[gi] = (state_reg == WRITE) && (gidx_reg == IDXW'(gi));
            assign ack[gi]   = (state_reg == ACK)   && (gidx_reg == IDXW'(gi));
        end
    endgenerate

    assign busy     = (state_reg != IDLE);
    assign q_valid  = q_valid_reg;
    assign owner    = owner_reg;
    assign xfer_cnt = xfer_cnt_reg;

endmodule : dff_bank_arbiter

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter: cycle-by-cycle vector table plus
// hand-written asynchronous-reset sequences.
module tb_dff_bank_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic        q_valid;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] xfer_cnt;

    int checks = 0;
    int errors = 0;

    dff_bank_arbiter #(
        .N_REQ (4),
        .WIDTH (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .data_in  (data_in),
        .grant    (grant),
        .ack      (ack),
        .q        (q),
        .q_valid  (q_valid),
        .owner    (owner),
        .busy     (busy),
        .xfer_cnt (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] din;
        logic [3:0]  grant;
        logic [3:0]  ack;
        logic [7:0]  q;
        logic        qv;
        logic [1:0]  owner;
        logic        busy;
        logic [15:0] cnt;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic [3:0] r, input logic [31:0] d,
                        input logic [3:0] g, input logic [3:0] a,
                        input logic [7:0] eq, input logic eqv,
                        input logic [1:0] eo, input logic eb,
                        input logic [15:0] ec);
        vec_t v;
        v.req = r; v.din = d; v.grant = g; v.ack = a; v.q = eq;
        v.qv = eqv; v.owner = eo; v.busy = eb; v.cnt = ec;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eg, input logic [3:0] ea,
                           input logic [7:0] eq, input logic eqv, input logic [1:0] eo,
                           input logic eb, input logic [15:0] ec);
        chk({tag, ".grant"},    32'(grant),    32'(eg));
        chk({tag, ".ack"},      32'(ack),      32'(ea));
        chk({tag, ".q"},        32'(q),        32'(eq));
        chk({tag, ".q_valid"},  32'(q_valid),  32'(eqv));
        chk({tag, ".owner"},    32'(owner),    32'(eo));
        chk({tag, ".busy"},     32'(busy),     32'(eb));
        chk({tag, ".xfer_cnt"}, 32'(xfer_cnt), 32'(ec));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] D_INC = 32'h13121110;
    localparam logic [31:0] D_A5  = 32'h000000A5;
    localparam logic [31:0] D_3C  = 32'h003C0000;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Each entry: inputs applied before an edge, outputs expected after it.
        // Round-robin sweep with req held and dropped in each ACK cycle.
        addv(4'b1111, D_INC, 4'b0001, 4'b0000, 8'h00, 0, 2'd0, 1, 16'd0);
        addv(4'b1111, D_INC, 4'b0000, 4'b0001, 8'h10, 1, 2'd0, 1, 16'd1);
        addv(4'b1110, D_INC, 4'b0000, 4'b0000, 8'h10, 1, 2'd0, 0, 16'd1);
        addv(4'b1111, D_INC, 4'b0010, 4'b0000, 8'h10, 1, 2'd0, 1, 16'd1);
        addv(4'b1111, D_INC, 4'b0000, 4'b0010, 8'h11, 1, 2'd1, 1, 16'd2);
        addv(4'b1101, D_INC, 4'b0000, 4'b0000, 8'h11, 1, 2'd1, 0, 16'd2);
        addv(4'b1111, D_INC, 4'b0100, 4'b0000, 8'h11, 1, 2'd1, 1, 16'd2);
        addv(4'b1111, D_INC, 4'b0000, 4'b0100, 8'h12, 1, 2'd2, 1, 16'd3);
        addv(4'b1011, D_INC, 4'b0000, 4'b0000, 8'h12, 1, 2'd2, 0, 16'd3);
        addv(4'b1111, D_INC, 4'b1000, 4'b0000, 8'h12, 1, 2'd2, 1, 16'd3);
        addv(4'b1111, D_INC, 4'b0000, 4'b1000, 8'h13, 1, 2'd3, 1, 16'd4);
        addv(4'b0111, D_INC, 4'b0000, 4'b0000, 8'h13, 1, 2'd3, 0, 16'd4);
        addv(4'b1111, D_INC, 4'b0001, 4'b0000, 8'h13, 1, 2'd3, 1, 16'd4);
        addv(4'b1111, D_INC, 4'b0000, 4'b0001, 8'h10, 1, 2'd0, 1, 16'd5);
        addv(4'b0000, D_INC, 4'b0000, 4'b0000, 8'h10, 1, 2'd0, 0, 16'd5);
        // Grant to 3, then pointer wraps to 0: 1001 grants 0 then 3.
        addv(4'b1000, D_INC, 4'b1000, 4'b0000, 8'h10, 1, 2'd0, 1, 16'd5);
        addv(4'b1000, D_INC, 4'b0000, 4'b1000, 8'h13, 1, 2'd3, 1, 16'd6);
        addv(4'b0000, D_INC, 4'b0000, 4'b0000, 8'h13, 1, 2'd3, 0, 16'd6);
        addv(4'b1001, D_INC, 4'b0001, 4'b0000, 8'h13, 1, 2'd3, 1, 16'd6);
        addv(4'b1001, D_INC, 4'b0000, 4'b0001, 8'h10, 1, 2'd0, 1, 16'd7);
        addv(4'b1000, D_INC, 4'b0000, 4'b0000, 8'h10, 1, 2'd0, 0, 16'd7);
        addv(4'b1001, D_INC, 4'b1000, 4'b0000, 8'h10, 1, 2'd0, 1, 16'd7);
        addv(4'b1001, D_INC, 4'b0000, 4'b1000, 8'h13, 1, 2'd3, 1, 16'd8);
        addv(4'b0000, D_INC, 4'b0000, 4'b0000, 8'h13, 1, 2'd3, 0, 16'd8);
        // Single requester 0 with data A5.
        addv(4'b0001, D_A5,  4'b0001, 4'b0000, 8'h13, 1, 2'd3, 1, 16'd8);
        addv(4'b0001, D_A5,  4'b0000, 4'b0001, 8'hA5, 1, 2'd0, 1, 16'd9);
        addv(4'b0000, D_A5,  4'b0000, 4'b0000, 8'hA5, 1, 2'd0, 0, 16'd9);
        // req[2] drops during its WRITE cycle: write still commits.
        addv(4'b0100, D_3C,  4'b0100, 4'b0000, 8'hA5, 1, 2'd0, 1, 16'd9);
        addv(4'b0000, D_3C,  4'b0000, 4'b0100, 8'h3C, 1, 2'd2, 1, 16'd10);
        addv(4'b0000, D_3C,  4'b0000, 4'b0000, 8'h3C, 1, 2'd2, 0, 16'd10);
        // New requests during ACK ignored; req held through ACK loses priority.
        addv(4'b0001, D_INC, 4'b0001, 4'b0000, 8'h3C, 1, 2'd2, 1, 16'd10);
        addv(4'b1111, D_INC, 4'b0000, 4'b0001, 8'h10, 1, 2'd0, 1, 16'd11);
        addv(4'b0001, D_INC, 4'b0000, 4'b0000, 8'h10, 1, 2'd0, 0, 16'd11);
        addv(4'b0011, D_INC, 4'b0010, 4'b0000, 8'h10, 1, 2'd0, 1, 16'd11);
        addv(4'b0011, D_INC, 4'b0000, 4'b0010, 8'h11, 1, 2'd1, 1, 16'd12);
        addv(4'b0000, D_INC, 4'b0000, 4'b0000, 8'h11, 1, 2'd1, 0, 16'd12);

        // Power-on reset.
        req = '0; data_in = '0; rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk_all("por", 4'b0, 4'b0, 8'h00, 0, 2'd0, 0, 16'd0);
        step(); step();
        rst_n = 1'b1;
        $display("reset released");

        // Table-driven cycle vectors.
        for (int i = 0; i < vq.size(); i++) begin
            req     = vq[i].req;
            data_in = vq[i].din;
            step();
            chk_all($sformatf("vec%0d", i), vq[i].grant, vq[i].ack, vq[i].q,
                    vq[i].qv, vq[i].owner, vq[i].busy, vq[i].cnt);
            $display("vec %0d req=%b grant=%b ack=%b q=%h owner=%0d cnt=%0d",
                     i, req, grant, ack, q, owner, xfer_cnt);
        end

        // Reset asserted mid-cycle while in ACK: outputs clear immediately.
        req = 4'b0100; data_in = D_INC;
        step();
        chk("rstack.grant_pre", 32'(grant), 32'h4);
        step();
        chk("rstack.q_pre", 32'(q), 32'h12);
        chk("rstack.ack_pre", 32'(ack), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk_all("rstack", 4'b0, 4'b0, 8'h00, 0, 2'd0, 0, 16'd0);
        $display("reset during ACK q=%h cnt=%0d", q, xfer_cnt);
        req = '0;
        step();
        rst_n = 1'b1;
        step();

        // Reset pulsed during WRITE for requester 1, then a clean transaction.
        req = 4'b0010;
        step();
        chk("rstwr.grant_pre", 32'(grant), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk_all("rstwr", 4'b0, 4'b0, 8'h00, 0, 2'd0, 0, 16'd0);
        step();
        rst_n = 1'b1;
        step();
        chk_all("post_w", 4'b0010, 4'b0000, 8'h00, 0, 2'd0, 1, 16'd0);
        step();
        chk_all("post_a", 4'b0000, 4'b0010, 8'h11, 1, 2'd1, 1, 16'd1);
        req = 4'b0000;
        step();
        chk_all("post_i", 4'b0000, 4'b0000, 8'h11, 1, 2'd1, 0, 16'd1);
        $display("post-reset transaction q=%h owner=%0d cnt=%0d", q, owner, xfer_cnt);

        // After serving 1, pointer is 2: 0011 must grant 0 (wraps past 2,3).
        req = 4'b0011;
        step();
        chk("rr_wrap.grant", 32'(grant), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dff_bank_arbiter
